// File: rtl/serial_word_arbiter.sv
// Round-robin arbiter that lends one LSB-first serial-to-parallel deserializer
// to one of n_ports requesters at a time and emits each completed word with its source index.
module serial_word_arbiter #(
    parameter  int n_ports = 4,
    parameter  int width   = 8,
    localparam int ID_W    = (n_ports > 1) ? $clog2(n_ports) : 1,
    localparam int CNT_W   = (width > 1) ? $clog2(width) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [n_ports-1:0] req_i,
    input  logic [n_ports-1:0] serial_valid_i,
    input  logic [n_ports-1:0] serial_data_i,
    output logic [n_ports-1:0] grant_o,
    output logic               parallel_valid_o,
    output logic [width-1:0]   parallel_data_o,
    output logic [ID_W-1:0]    parallel_id_o
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e             state_q,  state_d;
    logic [n_ports-1:0] grant_q,  grant_d;
    logic [ID_W-1:0]    gidx_q,   gidx_d;
    logic [ID_W-1:0]    ptr_q,    ptr_d;
    logic [ID_W-1:0]    pid_q,    pid_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [width-1:0]   shift_q,  shift_d;
    logic [width-1:0]   pdata_q,  pdata_d;
    logic               pvalid_q, pvalid_d;

    logic [ID_W-1:0]    winner;
    logic               found;
    logic [width-1:0]   shifted;
    logic               sel_req;
    logic               sel_valid;
    logic               sel_data;

    // (base + off) mod n_ports; both operands are already below n_ports.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= n_ports) begin
            sum = sum - n_ports;
        end
        return ID_W'(sum);
    endfunction

    // First requester at or after ptr_q, scanning with wrap-around.
    always_comb begin
        found  = 1'b0;
        winner = ptr_q;
        for (int i = 0; i < n_ports; i++) begin
            if (!found && req_i[wrap_add(ptr_q, i)]) begin
                found  = 1'b1;
                winner = wrap_add(ptr_q, i);
            end
        end
    end

    assign sel_req   = req_i[gidx_q];
    assign sel_valid = serial_valid_i[gidx_q];
    assign sel_data  = serial_data_i[gidx_q];

    always_comb begin
        shifted        = shift_q;
        shifted[cnt_q] = sel_data;
    end

    // NOTE: every next-state signal gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        pdata_d  = pdata_q;
        pid_d    = pid_q;
        pvalid_d = 1'b0;

        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (found) begin
                    grant_d[winner] = 1'b1;
                    gidx_d          = winner;
                    ptr_d           = wrap_add(winner, 1);
                    cnt_d           = '0;
                    shift_d         = '0;
                    state_d         = BUSY;
                end
            end
            BUSY: begin
                // A dropped request beats a same-cycle strobe: the partial word is discarded.
                if (!sel_req) begin
                    grant_d = '0;
                    state_d = IDLE;
                end else if (sel_valid) begin
                    shift_d = shifted;
                    if (cnt_q == CNT_W'(width - 1)) begin
                        pdata_d  = shifted;
                        pid_d    = gidx_q;
                        pvalid_d = 1'b1;
                        grant_d  = '0;
                        cnt_d    = '0;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            shift_q  <= '0;
            pdata_q  <= '0;
            pid_q    <= '0;
            pvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            pdata_q  <= pdata_d;
            pid_q    <= pid_d;
            pvalid_q <= pvalid_d;
        end
    end

    assign grant_o          = grant_q;
    assign parallel_valid_o = pvalid_q;
    assign parallel_data_o  = pdata_q;
    assign parallel_id_o    = pid_q;

endmodule

// File: tb/tb_serial_word_arbiter.sv
// Directed bench for serial_word_arbiter (4 ports, 8-bit words): single word,
// round-robin order, gapped strobes, abort, mid-word reset and back-to-back throughput.
module tb_serial_word_arbiter;

    localparam int NP = 4;
    localparam int W  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NP-1:0] req = '0;
    logic [NP-1:0] sv  = '0;
    logic [NP-1:0] sd  = '0;
    logic [NP-1:0] grant;
    logic          pvalid;
    logic [W-1:0]  pdata;
    logic [1:0]    pid;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    serial_word_arbiter #(.n_ports(NP), .width(W)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_i            (req),
        .serial_valid_i   (sv),
        .serial_data_i    (sd),
        .grant_o          (grant),
        .parallel_valid_o (pvalid),
        .parallel_data_o  (pdata),
        .parallel_id_o    (pid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        sv  = '0;
        sd  = '0;
        tick();
        tick();
        check("rst_grant",  32'(grant),  32'h0);
        check("rst_pvalid", 32'(pvalid), 32'h0);
        check("rst_pdata",  32'(pdata),  32'h0);
        check("rst_pid",    32'(pid),    32'h0);
        rst = 1'b0;
    endtask

    // Drives nbits of w LSB-first on port; other ports carry the inverted bit
    // (and strobe per noise) so a wrong selection corrupts the word.
    task automatic send_bits(input int port, input logic [7:0] w, input int nbits,
                             input bit gapped, input logic [3:0] noise);
        for (int i = 0; i < nbits; i++) begin
            sv       = noise;
            sv[port] = 1'b1;
            sd       = {NP{~w[i]}};
            sd[port] = w[i];
            tick();
            if (i < nbits - 1) begin
                check("no_early_pulse", 32'(pvalid), 32'h0);
                if (gapped) begin
                    sv = 4'b1001;
                    sd = 4'b1111;
                    tick();
                    check("no_gap_pulse", 32'(pvalid), 32'h0);
                end
            end
        end
    endtask

    logic [7:0] rr_w [5] = '{8'h3C, 8'hC5, 8'h5A, 8'h96, 8'h0F};
    int         rr_p [5] = '{0, 1, 2, 3, 0};
    logic [7:0] bb_w [3] = '{8'hE1, 8'h7B, 8'h20};
    int         last_pulse;

    initial begin
        // Single word from port 2.
        do_reset();
        req = 4'b0100;
        tick();
        check("single_grant", 32'(grant), 32'h4);
        send_bits(2, 8'h4D, 8, 1'b0, 4'b0000);
        check("single_pvalid", 32'(pvalid), 32'h1);
        check("single_pdata",  32'(pdata),  32'h4D);
        check("single_pid",    32'(pid),    32'h2);
        check("single_grant_off", 32'(grant), 32'h0);
        req = '0;
        sv  = '0;
        tick();
        check("single_one_pulse", 32'(pvalid), 32'h0);
        check("single_hold_data", 32'(pdata),  32'h4D);

        // Round-robin with every port requesting and strobing from reset.
        do_reset();
        req = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            check("rr_grant", 32'(grant), 32'h1 << rr_p[k]);
            send_bits(rr_p[k], rr_w[k], 8, 1'b0, 4'b1111);
            check("rr_pvalid", 32'(pvalid), 32'h1);
            check("rr_pid",    32'(pid),    32'(rr_p[k]));
            check("rr_pdata",  32'(pdata),  32'(rr_w[k]));
            check("rr_idle",   32'(grant),  32'h0);
            sv = '0;
            tick();
        end
        check("rr_sixth_grant", 32'(grant), 32'h2);
        req = '0;
        tick();
        check("rr_drop_grant",  32'(grant),  32'h0);
        check("rr_drop_pvalid", 32'(pvalid), 32'h0);

        // Gapped strobes on port 1 while ports 0 and 3 toggle their strobes.
        req = 4'b0010;
        tick();
        check("gap_grant", 32'(grant), 32'h2);
        send_bits(1, 8'hA6, 8, 1'b1, 4'b0000);
        check("gap_pvalid", 32'(pvalid), 32'h1);
        check("gap_pdata",  32'(pdata),  32'hA6);
        check("gap_pid",    32'(pid),    32'h1);
        req = '0;
        sv  = '0;
        tick();
        check("gap_one_pulse", 32'(pvalid), 32'h0);

        // Abort: port 3 drops req after 5 bits, with a strobe on the same edge.
        req = 4'b1000;
        tick();
        check("abort_grant", 32'(grant), 32'h8);
        send_bits(3, 8'hFF, 5, 1'b0, 4'b0000);
        req = '0;
        sv  = 4'b1000;
        sd  = 4'b1000;
        tick();
        check("abort_grant_off", 32'(grant),  32'h0);
        check("abort_no_pulse",  32'(pvalid), 32'h0);
        check("abort_hold_data", 32'(pdata),  32'hA6);
        check("abort_hold_id",   32'(pid),    32'h1);
        req = 4'b1001;
        sv  = '0;
        sd  = '0;
        tick();
        check("abort_next_port0", 32'(grant),  32'h1);
        check("abort_still_none", 32'(pvalid), 32'h0);
        req = '0;
        tick();
        check("abort_release", 32'(grant), 32'h0);

        // Reset in the middle of a port 1 word.
        req = 4'b0010;
        tick();
        check("mrst_grant", 32'(grant), 32'h2);
        send_bits(1, 8'hFF, 3, 1'b0, 4'b0000);
        rst = 1'b1;
        req = '0;
        sv  = '0;
        tick();
        check("mrst_grant_off", 32'(grant),  32'h0);
        check("mrst_pvalid",    32'(pvalid), 32'h0);
        check("mrst_pdata",     32'(pdata),  32'h0);
        check("mrst_pid",       32'(pid),    32'h0);
        rst = 1'b0;
        req = 4'b0011;
        tick();
        check("mrst_port0_first", 32'(grant), 32'h1);
        req = '0;
        tick();
        check("mrst_release", 32'(grant), 32'h0);

        // Back-to-back words from port 0; producer idles in each grant cycle.
        req        = 4'b0001;
        last_pulse = 0;
        tick();
        for (int k = 0; k < 3; k++) begin
            check("b2b_grant", 32'(grant), 32'h1);
            sv = '0;
            tick();
            send_bits(0, bb_w[k], 8, 1'b0, 4'b0000);
            check("b2b_pvalid", 32'(pvalid), 32'h1);
            check("b2b_pid",    32'(pid),    32'h0);
            check("b2b_pdata",  32'(pdata),  32'(bb_w[k]));
            if (k > 0) begin
                check("b2b_period", 32'(cyc - last_pulse), 32'd10);
            end
            last_pulse = cyc;
            sv = '0;
            tick();
        end
        req = '0;
        tick();
        tick();
        check("end_idle", 32'(grant), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
